// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
// The optional parity bit is selected with the PISO_PARITY_EN macro; see
// piso_shift_register.sv.
package piso_pkg;

  // IDLE waits for a word; SHIFT drives the frame onto serial_out.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // The bit counter must be able to hold WIDTH, which is the last index
  // when the parity bit extends the frame.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage : piso_pkg

// File: rtl/piso_bit_counter.sv
// Bit counter for one serial frame. Counts the bits already shifted and flags
// the final bit of a FRAME_LEN-bit frame. It saturates at the last index and
// never wraps.
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned FRAME_LEN = WIDTH
) (
  input  logic clk,
  input  logic reset,     // synchronous, active low
  input  logic clear_i,   // restart at bit 0 (new frame captured)
  input  logic enable_i,  // one more bit has been shifted
  output logic last_o     // current bit is the final bit of the frame
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise step only below the last index.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !last_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == LAST_IDX);

endmodule : piso_bit_counter

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register with a valid/ready load port.
// Optional feature macro: PISO_PARITY_EN -- when defined, an even-parity bit
// (XOR of the captured word) follows the WIDTH data bits.
//
// Handshake: a word is transferred on a rising edge where load_valid and
// load_ready are both high; load_ready is high only in IDLE, so load_valid is
// don't-care while a frame is being shifted, and the source must hold data_in
// stable only during the transfer cycle.
module piso_shift_register
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,        // synchronous, active low
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_enable,
  output logic             serial_out,
  output logic             busy,
  output logic             frame_done
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FW = WIDTH + 1;
`else
  localparam int unsigned FW = WIDTH;
`endif

  piso_state_e   state_q, state_d;
  logic [FW-1:0] sr_q, sr_d;          // remaining bits, next bit at the top
  logic          serial_out_q, serial_out_d;
  logic          frame_done_q, frame_done_d;
  logic          cnt_clear, cnt_en, cnt_last;

  logic [WIDTH-1:0] ordered_w;        // data bits in transmit order, first at MSB
  logic [FW-1:0]    frame_w;          // complete frame, first bit at MSB

  // Put the data bits in transmit order so shifting is always towards the MSB.
  always_comb begin
    ordered_w = data_in;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        ordered_w[i] = data_in[int'(WIDTH) - 1 - i];
      end
    end
  end

`ifdef PISO_PARITY_EN
  assign frame_w = {ordered_w, ^data_in};
`else
  assign frame_w = ordered_w;
`endif

  piso_bit_counter #(
    .WIDTH     (WIDTH),
    .FRAME_LEN (FW)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear),
    .enable_i (cnt_en),
    .last_o   (cnt_last)
  );

  // Next-state and datapath decisions; every register holds unless told otherwise.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    serial_out_d = serial_out_q;
    frame_done_d = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        serial_out_d = 1'b0;
        if (load_valid) begin
          state_d      = SHIFT;
          serial_out_d = frame_w[FW-1];
          sr_d         = {frame_w[FW-2:0], 1'b0};
          cnt_clear    = 1'b1;
        end
      end
      SHIFT: begin
        if (shift_enable) begin
          if (cnt_last) begin
            state_d      = IDLE;
            serial_out_d = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            cnt_en       = 1'b1;
            serial_out_d = sr_q[FW-1];
            sr_d         = {sr_q[FW-2:0], 1'b0};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      serial_out_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      serial_out_q <= serial_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q == SHIFT);
  assign serial_out = serial_out_q;
  assign frame_done = frame_done_q;

endmodule : piso_shift_register

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register. Two instances (MSB-first and
// LSB-first) share all inputs; expected bit sequences are hand-written
// constants, with PISO_PARITY_EN selecting the 5-bit frame variants.
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       load_valid;
  logic       shift_enable;

  logic       m_ready, m_sout, m_busy, m_done;
  logic       l_ready, l_sout, l_busy, l_done;

  int n_checks;
  int n_fail;

  piso_shift_register #(.WIDTH(4), .LSB_FIRST(0)) dut_msb (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (m_ready),
    .shift_enable (shift_enable),
    .serial_out   (m_sout),
    .busy         (m_busy),
    .frame_done   (m_done)
  );

  piso_shift_register #(.WIDTH(4), .LSB_FIRST(1)) dut_lsb (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (l_ready),
    .shift_enable (shift_enable),
    .serial_out   (l_sout),
    .busy         (l_busy),
    .frame_done   (l_done)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both instances idle with no pulse pending.
  task automatic check_idle(input string tag, input logic exp_done);
    check({tag, "_m_ready"}, {7'd0, m_ready}, 8'd1);
    check({tag, "_m_busy"},  {7'd0, m_busy},  8'd0);
    check({tag, "_m_sout"},  {7'd0, m_sout},  8'd0);
    check({tag, "_m_done"},  {7'd0, m_done},  {7'd0, exp_done});
    check({tag, "_l_ready"}, {7'd0, l_ready}, 8'd1);
    check({tag, "_l_busy"},  {7'd0, l_busy},  8'd0);
    check({tag, "_l_sout"},  {7'd0, l_sout},  8'd0);
    check({tag, "_l_done"},  {7'd0, l_done},  {7'd0, exp_done});
  endtask

  // Load word w at the next edge and follow the frame to its frame_done cycle.
  // exp_m / exp_l hold the expected bits, first bit at index FLEN-1.
  // stalls: shift_enable low cycles inserted after the first bit.
  // interfere: hold load_valid high with 4'b0000 while the frame shifts.
  // Returns in the frame_done cycle with load_valid low.
  task automatic run_frame(input string tag, input logic [3:0] w,
                           input logic [7:0] exp_m, input logic [7:0] exp_l,
                           input int stalls, input logic interfere);
    int cycles;
    data_in      = w;
    load_valid   = 1'b1;
    shift_enable = 1'b1;
    tick();
    cycles     = 1;
    load_valid = interfere;
    data_in    = 4'b0000;
    for (int i = 0; i < FLEN; i++) begin
      check({tag, "_m_bit"}, {7'd0, m_sout}, {7'd0, exp_m[FLEN-1-i]});
      check({tag, "_l_bit"}, {7'd0, l_sout}, {7'd0, exp_l[FLEN-1-i]});
      check({tag, "_busy"},  {6'd0, m_busy, l_busy}, 8'b11);
      check({tag, "_ready"}, {6'd0, m_ready, l_ready}, 8'b00);
      check({tag, "_done"},  {6'd0, m_done, l_done}, 8'b00);
      if (i == 0 && stalls > 0) begin
        shift_enable = 1'b0;
        for (int s = 0; s < stalls; s++) begin
          tick();
          cycles++;
          check({tag, "_m_hold"}, {7'd0, m_sout}, {7'd0, exp_m[FLEN-1]});
          check({tag, "_l_hold"}, {7'd0, l_sout}, {7'd0, exp_l[FLEN-1]});
          check({tag, "_hold_busy"}, {6'd0, m_busy, l_busy}, 8'b11);
        end
        shift_enable = 1'b1;
      end
      tick();
      cycles++;
    end
    load_valid = 1'b0;
    check({tag, "_latency"}, 8'(cycles), 8'(FLEN + 1 + stalls));
    check_idle({tag, "_end"}, 1'b1);
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    data_in      = 4'b1111;
    load_valid   = 1'b1;      // handshake during reset must be ignored
    shift_enable = 1'b1;
    tick();
    tick();
    check_idle("reset", 1'b0);
    load_valid = 1'b0;
    reset      = 1'b1;
    tick();
    check_idle("post_reset", 1'b0);

`ifdef PISO_PARITY_EN
    // 1011: parity 1; 1100: parity 0; 1001: parity 0
    run_frame("f1011", 4'b1011, 8'b10111, 8'b11011, 0, 1'b0);
    tick(); check_idle("f1011_after", 1'b0);
    run_frame("stall", 4'b1100, 8'b11000, 8'b00110, 2, 1'b0);
    tick(); check_idle("stall_after", 1'b0);
    run_frame("busyld", 4'b1011, 8'b10111, 8'b11011, 0, 1'b1);
    // back-to-back: next word loaded in the frame_done cycle
    run_frame("f1001", 4'b1001, 8'b10010, 8'b10010, 0, 1'b0);
    tick(); check_idle("f1001_after", 1'b0);
`else
    run_frame("f1011", 4'b1011, 8'b1011, 8'b1101, 0, 1'b0);
    tick(); check_idle("f1011_after", 1'b0);
    run_frame("stall", 4'b1100, 8'b1100, 8'b0011, 2, 1'b0);
    tick(); check_idle("stall_after", 1'b0);
    run_frame("busyld", 4'b1011, 8'b1011, 8'b1101, 0, 1'b1);
    run_frame("f1001", 4'b1001, 8'b1001, 8'b1001, 0, 1'b0);
    tick(); check_idle("f1001_after", 1'b0);
`endif

    // Reset mid-frame, after the second bit of 1011 is on the line.
    data_in    = 4'b1011;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    check("mid_bit0", {6'd0, m_sout, l_sout}, 8'b11);
    tick();
    check("mid_bit1", {6'd0, m_sout, l_sout}, 8'b01);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle("midreset", 1'b0);
    tick();
    check_idle("midreset_next", 1'b0);
`ifdef PISO_PARITY_EN
    run_frame("f0110", 4'b0110, 8'b01100, 8'b01100, 0, 1'b0);
`else
    run_frame("f0110", 4'b0110, 8'b0110, 8'b0110, 0, 1'b0);
`endif
    tick();
    check_idle("f0110_after", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_piso_shift_register
